keygen_mul_pipe_param: RTL and testbench

//  Parametrised pipelined multiplier / multiply-accumulate for the keygen datapath.

---
 rtl/keygen_mul_pipe_param.sv | 148 ++++++++++++++
 tb/tb_keygen_mul_pipe_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keygen_mul_pipe_param.sv
// rtl/keygen_mul_pipe_param.sv - parametrised pipelined multiplier / multiply-accumulate
//
// Purpose: keygen datapath multiplier with configurable operand widths, signedness,
// pipeline depth and optional accumulation in the final stage. A valid bit travels
// alongside the data; ce freezes the whole pipeline.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   ce         in   clock enable, 0 holds every pipeline register
//   in_valid   in   din0/din1/acc_clr valid this cycle
//   acc_clr    in   (ACC_EN=1) restart the accumulator with this sample's product
//   din0       in   multiplicand, DIN0_WIDTH bits
//   din1       in   multiplier, DIN1_WIDTH bits
//   out_valid  out  dout carries a new result
//   dout       out  product (or running sum when ACC_EN=1), DOUT_WIDTH bits
module keygen_mul_pipe_param #(
    parameter int DIN0_WIDTH  = 13,
    parameter int DIN1_WIDTH  = 8,
    parameter int DOUT_WIDTH  = 13,
    parameter int NUM_STAGE   = 4,
    parameter int DIN0_SIGNED = 1,
    parameter int DIN1_SIGNED = 0,
    parameter int ACC_EN      = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  acc_clr,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    // Multiply wide enough to cover the output so that sign/zero extension of the
    // product falls out of the operand extension.
    localparam int MW = (DOUT_WIDTH > PW) ? DOUT_WIDTH : PW;
    // Entries 0..NS-1 of the data chain are stages 2..NUM_STAGE.
    localparam int NS = NUM_STAGE - 1;

    if (NUM_STAGE < 2 || NUM_STAGE > 8) begin : g_bad_num_stage
        $error("keygen_mul_pipe_param: NUM_STAGE must be in 2..8");
    end
    if (ACC_EN != 0 && NUM_STAGE < 3) begin : g_bad_acc_depth
        $error("keygen_mul_pipe_param: ACC_EN=1 needs NUM_STAGE >= 3");
    end

    // Stage 1: operand capture
    logic [DIN0_WIDTH-1:0] din0_q;
    logic [DIN1_WIDTH-1:0] din1_q;
    logic                  valid1_q;
    logic                  clr1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din0_q   <= '0;
            din1_q   <= '0;
            valid1_q <= 1'b0;
            clr1_q   <= 1'b0;
        end else if (ce) begin
            valid1_q <= in_valid;
            if (in_valid) begin
                din0_q <= din0;
                din1_q <= din1;
                clr1_q <= acc_clr;
            end
        end
    end

    // Product: each operand extended by its own signedness flag, then multiplied.
    // Only the low DOUT_WIDTH bits are ever observable, so only those are kept.
    logic          sign0;
    logic          sign1;
    logic [MW-1:0] op0_ext;
    logic [MW-1:0] op1_ext;
    logic [DOUT_WIDTH-1:0] prod_d;

    always_comb begin
        sign0   = (DIN0_SIGNED != 0) && din0_q[DIN0_WIDTH-1];
        sign1   = (DIN1_SIGNED != 0) && din1_q[DIN1_WIDTH-1];
        op0_ext = {{(MW-DIN0_WIDTH){sign0}}, din0_q};
        op1_ext = {{(MW-DIN1_WIDTH){sign1}}, din1_q};
        prod_d  = DOUT_WIDTH'(op0_ext * op1_ext);
    end

    // Stages 2..NUM_STAGE: product register, delay registers, optional accumulator.
    logic [DOUT_WIDTH-1:0] src_data [NS];
    logic [NS-1:0]         src_valid;
    logic [NS-1:0]         src_clr;
    logic [DOUT_WIDTH-1:0] data_q   [NS];
    logic [DOUT_WIDTH-1:0] data_d   [NS];
    logic [NS-1:0]         valid_q;
    logic [NS-1:0]         valid_d;
    logic [NS-1:0]         clr_q;
    logic [NS-1:0]         clr_d;

    always_comb begin
        src_data[0]  = prod_d;
        src_valid[0] = valid1_q;
        src_clr[0]   = clr1_q;
        for (int i = 1; i < NS; i++) begin
            src_data[i]  = data_q[i-1];
            src_valid[i] = valid_q[i-1];
            src_clr[i]   = clr_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            valid_d[i] = src_valid[i];
            data_d[i]  = data_q[i];
            clr_d[i]   = clr_q[i];
            // Bubbles leave data untouched: dout keeps its last value and the
            // accumulator holds.
            if (src_valid[i]) begin
                clr_d[i] = src_clr[i];
                if (ACC_EN != 0 && i == NS - 1) begin
                    data_d[i] = src_clr[i] ? src_data[i] : data_q[i] + src_data[i];
                end else begin
                    data_d[i] = src_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            clr_q   <= '0;
        end else if (ce) begin
            for (int i = 0; i < NS; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            clr_q   <= clr_d;
        end
    end

    assign dout      = data_q[NS-1];
    assign out_valid = valid_q[NS-1];

endmodule

// File: tb/tb_keygen_mul_pipe_param.sv
// tb/tb_keygen_mul_pipe_param.sv - testbench for keygen_mul_pipe_param
module tb_keygen_mul_pipe_param;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        in_valid;
    logic        acc_clr;
    logic [12:0] din0;
    logic [7:0]  din1;
    logic        out_valid;
    logic [12:0] dout;
    logic        acc_valid;
    logic [12:0] acc_dout;

    int checks;
    int failures;

    keygen_mul_pipe_param u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .acc_clr   (acc_clr),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .dout      (dout)
    );

    keygen_mul_pipe_param #(
        .NUM_STAGE (4),
        .ACC_EN    (1)
    ) u_acc (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .acc_clr   (acc_clr),
        .din0      (din0),
        .din1      (din1),
        .out_valid (acc_valid),
        .dout      (acc_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce = 1'b1; in_valid = 1'b0; acc_clr = 1'b0;
        din0 = 13'd0; din1 = 8'd0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (dout !== 13'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
        checks++; if (acc_valid !== 1'b0) begin failures++; $display("FAIL reset_acc_valid got=%b exp=0", acc_valid); end
        checks++; if (acc_dout !== 13'h0000) begin failures++; $display("FAIL reset_acc_dout got=%h exp=0000", acc_dout); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_defaults();
        din0 = 13'h1FFB; din1 = 8'd200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int e = 2; e <= 6; e++) begin
            step();
            checks++;
            if (out_valid !== (e == 4)) begin failures++; $display("FAIL defaults_valid e=%0d got=%b exp=%b", e, out_valid, (e == 4)); end
            if (e >= 4) begin
                checks++;
                if (dout !== 13'h1C18) begin failures++; $display("FAIL defaults_dout e=%0d got=%h exp=1c18", e, dout); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [12:0] exp_d;
        din0 = 13'd4095; din1 = 8'd255; in_valid = 1'b1;
        step();
        din0 = 13'h1000; din1 = 8'd255;
        step();
        in_valid = 1'b0;
        for (int e = 3; e <= 6; e++) begin
            step();
            exp_d = (e == 4) ? 13'h0F01 : 13'h1000;
            checks++;
            if (out_valid !== (e == 4 || e == 5)) begin failures++; $display("FAIL wrap_valid e=%0d got=%b", e, out_valid); end
            if (e >= 4) begin
                checks++;
                if (dout !== exp_d) begin failures++; $display("FAIL wrap_dout e=%0d got=%h exp=%h", e, dout, exp_d); end
            end
        end
    endtask

    task automatic test_stall();
        din0 = 13'd100; din1 = 8'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        din0 = 13'h1FFF; din1 = 8'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || dout !== 13'h012C) begin failures++; $display("FAIL stall_first got v=%b d=%h exp v=1 d=012c", out_valid, dout); end
        ce = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || dout !== 13'h012C) begin failures++; $display("FAIL stall_hold s=%0d got v=%b d=%h exp v=1 d=012c", s, out_valid, dout); end
        end
        ce = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || dout !== 13'h012C) begin failures++; $display("FAIL stall_bubble got v=%b d=%h exp v=0 d=012c", out_valid, dout); end
        step();
        checks++; if (out_valid !== 1'b1 || dout !== 13'h1FFF) begin failures++; $display("FAIL stall_second got v=%b d=%h exp v=1 d=1fff", out_valid, dout); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_after got v=%b exp v=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_q[$];
        logic [12:0] exp_d;
        logic [16:0] issued;
        logic        exp_v;
        logic        prev_v;
        int          prod;
        int          nvalid;
        int          rises;
        issued = '0;
        prev_v = 1'b0;
        nvalid = 0;
        rises  = 0;
        for (int c = 0; c < 23; c++) begin
            if (c < 17 && c != 8) begin
                din0 = 13'($urandom);
                din1 = 8'($urandom);
                in_valid = 1'b1;
                issued[c] = 1'b1;
                prod = int'($signed(din0)) * int'(din1);
                exp_d = prod[12:0];
                exp_q.push_back(exp_d);
            end else begin
                in_valid = 1'b0;
            end
            step();
            exp_v = (c >= 3 && c - 3 < 17) ? issued[c-3] : 1'b0;
            checks++;
            if (out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_valid, exp_v); end
            if (out_valid === 1'b1) begin
                nvalid++;
                if (!prev_v) rises++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra c=%0d got=%h exp=none", c, dout);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (dout !== exp_d) begin failures++; $display("FAIL b2b_dout c=%0d got=%h exp=%h", c, dout, exp_d); end
                end
            end
            prev_v = out_valid;
        end
        checks++; if (nvalid != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", nvalid); end
        checks++; if (rises != 2) begin failures++; $display("FAIL b2b_gaps got=%0d exp=1", rises - 1); end
    endtask

    task automatic test_acc();
        logic [12:0] a_v   [5] = '{13'd10, 13'd20, 13'h1FF9, 13'd0, 13'd4};
        logic [7:0]  b_v   [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd4};
        logic        c_v   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        iv_v  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        ev    [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [12:0] ed    [9] = '{13'd0, 13'd0, 13'd0, 13'd30, 13'd70, 13'd63, 13'd63, 13'd16, 13'd16};
        for (int e = 1; e <= 9; e++) begin
            if (e <= 5) begin
                din0 = a_v[e-1]; din1 = b_v[e-1]; acc_clr = c_v[e-1]; in_valid = iv_v[e-1];
            end else begin
                in_valid = 1'b0; acc_clr = 1'b0;
            end
            step();
            checks++;
            if (acc_valid !== ev[e-1]) begin failures++; $display("FAIL acc_valid e=%0d got=%b exp=%b", e, acc_valid, ev[e-1]); end
            if (e >= 4) begin
                checks++;
                if (acc_dout !== ed[e-1]) begin failures++; $display("FAIL acc_dout e=%0d got=%0d exp=%0d", e, acc_dout, ed[e-1]); end
            end
        end
        acc_clr = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int k = 1; k <= 4; k++) begin
            din0 = 13'(k); din1 = 8'(k); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || dout !== 13'd1) begin failures++; $display("FAIL midrst_pre got v=%b d=%h exp v=1 d=0001", out_valid, dout); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || dout !== 13'd0) begin failures++; $display("FAIL midrst_now got v=%b d=%h exp v=0 d=0000", out_valid, dout); end
        checks++; if (acc_valid !== 1'b0 || acc_dout !== 13'd0) begin failures++; $display("FAIL midrst_acc got v=%b d=%h exp v=0 d=0000", acc_valid, acc_dout); end
        step();
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || dout !== 13'd0 || acc_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_stale c=%0d got v=%b d=%h av=%b exp all 0", c, out_valid, dout, acc_valid);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_defaults();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_acc();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
